vector_pe_sequencer: RTL and testbench

Element-loop controller sitting directly upstream of the vector processing element (PE). It accepts one vector arithmetic command from the coprocessor decode stage and reads packed 32-bit source words from the vector register file (VRF). It issues each word pair to the PE with a start pulse, waits for PE done, and writes the PE result back to the destination register. It reports completion or error to the coprocessor.

---
 rtl/vector_pkg.sv | 46 ++++
 rtl/vec_word_count.sv | 25 ++
 rtl/vector_pe_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_vector_pe_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared opcodes, SEW encodings, FSM states and word-count helper
// for the vector PE element-loop sequencer.
package vector_pkg;

    localparam logic [7:0] OP_VADD  = 8'h00;
    localparam logic [7:0] OP_VMUL  = 8'h01;
    localparam logic [7:0] OP_VDOT  = 8'h02;
    localparam logic [7:0] OP_VARP0 = 8'h03;
    localparam logic [7:0] OP_VARP1 = 8'h04;
    localparam logic [7:0] OP_VARP2 = 8'h05;

    localparam logic [9:0] SEW_8  = 10'd8;
    localparam logic [9:0] SEW_16 = 10'd16;
    localparam logic [9:0] SEW_32 = 10'd32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } seq_state_e;

    // Words touched after clamping vl to VLMAX; 0 for unsupported SEW.
    function automatic int unsigned vec_words(
        input logic [9:0]  sew,
        input logic [7:0]  vl,
        input int unsigned vlen
    );
        int unsigned vlmax;
        int unsigned vlc;
        int unsigned bits;
        case (sew)
            SEW_8:   vlmax = vlen >> 3;
            SEW_16:  vlmax = vlen >> 4;
            SEW_32:  vlmax = vlen >> 5;
            default: vlmax = 0;
        endcase
        vlc  = (32'(vl) > vlmax) ? vlmax : 32'(vl);
        bits = vlc * 32'(sew);
        return (bits + 31) >> 5;
    endfunction

endpackage

// File: rtl/vec_word_count.sv
// SEW legality check and clamped word count for one vector command.
module vec_word_count
    import vector_pkg::*;
#(
    parameter int VLEN   = 128,
    parameter int WIDX_W = 2
) (
    input  logic [9:0]      sew_i,
    input  logic [7:0]      vl_i,
    output logic [WIDX_W:0] n_o,
    output logic            sew_illegal_o
);

    always_comb begin
        sew_illegal_o = 1'b1;
        unique case (sew_i)
            SEW_8, SEW_16, SEW_32: sew_illegal_o = 1'b0;
            default: ;
        endcase
        n_o = '0;
        if (!sew_illegal_o)
            n_o = (WIDX_W+1)'(vec_words(sew_i, vl_i, VLEN));
    end

endmodule

// File: rtl/vector_pe_sequencer.sv
// Element-loop controller: reads VRF word pairs, drives the PE one
// word at a time and writes each PE result back to vd.
module vector_pe_sequencer
    import vector_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int WIDX_W     = 2,
    parameter int PE_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_instr,
    input  logic [4:0]         cmd_vs1,
    input  logic [4:0]         cmd_vs2,
    input  logic [4:0]         cmd_vd,
    input  logic [7:0]         cmd_vl,
    input  logic [9:0]         cmd_sew,
    input  logic [3:0]         cmd_vap,
    output logic               rf_ren,
    output logic [5+WIDX_W-1:0] rf_raddr1,
    output logic [5+WIDX_W-1:0] rf_raddr2,
    output logic [5+WIDX_W-1:0] rf_raddr3,
    input  logic [31:0]        rf_rdata1,
    input  logic [31:0]        rf_rdata2,
    input  logic [31:0]        rf_rdata3,
    output logic               rf_wen,
    output logic [5+WIDX_W-1:0] rf_waddr,
    output logic [31:0]        rf_wdata,
    output logic [7:0]         pe_instruction,
    output logic               pe_start,
    output logic [31:0]        pe_opA,
    output logic [31:0]        pe_opB,
    output logic [31:0]        pe_opC,
    output logic [9:0]         pe_SEW,
    output logic [3:0]         pe_vap,
    input  logic               pe_done,
    input  logic [31:0]        pe_out,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               seq_err
);

    localparam int TMO_W = $clog2(PE_TIMEOUT + 1);

    seq_state_e state_q, state_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [WIDX_W:0]   n_q, n_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        instr_q, instr_d;
    logic [4:0]        vs1_q, vs1_d;
    logic [4:0]        vs2_q, vs2_d;
    logic [4:0]        vd_q, vd_d;
    logic [9:0]        sew_q, sew_d;
    logic [3:0]        vap_q, vap_d;
    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic [31:0]       opc_q, opc_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [WIDX_W:0]   wc_n;
    logic              wc_ill;

    vec_word_count #(
        .VLEN   (VLEN),
        .WIDX_W (WIDX_W)
    ) u_wc (
        .sew_i         (cmd_sew),
        .vl_i          (cmd_vl),
        .n_o           (wc_n),
        .sew_illegal_o (wc_ill)
    );

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        n_d     = n_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        instr_d = instr_q;
        vs1_d   = vs1_q;
        vs2_d   = vs2_q;
        vd_d    = vd_q;
        sew_d   = sew_q;
        vap_d   = vap_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        opc_d   = opc_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    instr_d = cmd_instr;
                    vs1_d   = cmd_vs1;
                    vs2_d   = cmd_vs2;
                    vd_d    = cmd_vd;
                    sew_d   = cmd_sew;
                    vap_d   = cmd_vap;
                    widx_d  = '0;
                    tmo_d   = '0;
                    n_d     = wc_n;
                    err_d   = wc_ill;
                    state_d = (wc_ill || wc_n == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                opa_d   = rf_rdata1;
                opb_d   = rf_rdata2;
                opc_d   = rf_rdata3;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            // pe_done may still be high from the previous word; it is
            // only honoured here, after this word's start pulse.
            S_WAIT: begin
                if (pe_done) begin
                    wdata_d = pe_out;
                    state_d = S_WRITE;
                end else if (tmo_q == TMO_W'(PE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                widx_d = widx_q + 1'b1;
                if ({1'b0, widx_q} + 1'b1 == n_q)
                    state_d = S_DONE;
                else
                    state_d = S_READ;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            widx_q  <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            instr_q <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            vd_q    <= '0;
            sew_q   <= '0;
            vap_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            n_q     <= n_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            instr_q <= instr_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            vd_q    <= vd_d;
            sew_q   <= sew_d;
            vap_q   <= vap_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            wdata_q <= wdata_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign rf_ren         = (state_q == S_READ);
    assign pe_start       = (state_q == S_ISSUE);
    assign rf_wen         = (state_q == S_WRITE);
    assign seq_done       = (state_q == S_DONE);
    assign seq_err        = seq_done & err_q;
    assign seq_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign rf_raddr1      = {vs1_q, widx_q};
    assign rf_raddr2      = {vs2_q, widx_q};
    assign rf_raddr3      = {vd_q, widx_q};
    assign rf_waddr       = {vd_q, widx_q};
    assign rf_wdata       = wdata_q;
    assign pe_instruction = instr_q;
    assign pe_SEW         = sew_q;
    assign pe_vap         = vap_q;
    assign pe_opA         = opa_q;
    assign pe_opB         = opb_q;
    assign pe_opC         = opc_q;

endmodule

// File: tb/tb_vector_pe_sequencer.sv
// Directed scoreboard bench for vector_pe_sequencer with a VRF model
// and a behavioural PE.
module tb_vector_pe_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_instr = '0;
    logic [4:0]  cmd_vs1 = '0;
    logic [4:0]  cmd_vs2 = '0;
    logic [4:0]  cmd_vd = '0;
    logic [7:0]  cmd_vl = '0;
    logic [9:0]  cmd_sew = '0;
    logic [3:0]  cmd_vap = '0;
    logic        rf_ren;
    logic [6:0]  rf_raddr1, rf_raddr2, rf_raddr3;
    logic [31:0] rf_rdata1 = '0;
    logic [31:0] rf_rdata2 = '0;
    logic [31:0] rf_rdata3 = '0;
    logic        rf_wen;
    logic [6:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [7:0]  pe_instruction;
    logic        pe_start;
    logic [31:0] pe_opA, pe_opB, pe_opC;
    logic [9:0]  pe_SEW;
    logic [3:0]  pe_vap;
    logic        pe_done = 1'b0;
    logic [31:0] pe_out = '0;
    logic        seq_busy, seq_done, seq_err;

    vector_pe_sequencer #(
        .VLEN       (128),
        .WIDX_W     (2),
        .PE_TIMEOUT (255)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_instr      (cmd_instr),
        .cmd_vs1        (cmd_vs1),
        .cmd_vs2        (cmd_vs2),
        .cmd_vd         (cmd_vd),
        .cmd_vl         (cmd_vl),
        .cmd_sew        (cmd_sew),
        .cmd_vap        (cmd_vap),
        .rf_ren         (rf_ren),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_raddr3      (rf_raddr3),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .rf_rdata3      (rf_rdata3),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .pe_instruction (pe_instruction),
        .pe_start       (pe_start),
        .pe_opA         (pe_opA),
        .pe_opB         (pe_opB),
        .pe_opC         (pe_opC),
        .pe_SEW         (pe_SEW),
        .pe_vap         (pe_vap),
        .pe_done        (pe_done),
        .pe_out         (pe_out),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .seq_err        (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] vrf [0:31][0:3];
    int          total = 0;
    int          passed = 0;
    int          n_start = 0;
    int          n_ren = 0;
    int          n_wr = 0;
    logic        pe_en = 1'b1;

    function automatic logic [31:0] pe_fn(input logic [31:0] a, b, c);
        return (a + b) ^ {c[15:0], c[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // VRF read port: data valid the cycle after the strobe
    always @(posedge clk) begin
        if (rf_ren) begin
            rf_rdata1 <= vrf[rf_raddr1[6:2]][rf_raddr1[1:0]];
            rf_rdata2 <= vrf[rf_raddr2[6:2]][rf_raddr2[1:0]];
            rf_rdata3 <= vrf[rf_raddr3[6:2]][rf_raddr3[1:0]];
        end
    end

    // PE answers during the ISSUE cycle and leaves done high
    always @(negedge clk) begin
        if (pe_start) begin
            pe_out  = pe_fn(pe_opA, pe_opB, pe_opC);
            pe_done = pe_en;
        end else if (!pe_en) begin
            pe_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (pe_start) n_start++;
        if (rf_ren) n_ren++;
        if (rf_ren || rf_wen) chk("ren_wen_excl", 64'(rf_ren & rf_wen), 0);
        if (rf_wen) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'(rf_wen), 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(rf_waddr), 64'(e.addr));
                chk("wr_data", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    task automatic push_writes(input logic [4:0] s1, s2, d, input int nwr);
        for (int w = 0; w < nwr; w++) begin
            wr_t e;
            e.addr = {d, 2'(w)};
            e.data = pe_fn(vrf[s1][w], vrf[s2][w], vrf[d][w]);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_cmd(
        input string      tag,
        input logic [7:0] ins,
        input logic [4:0] s1, s2, d,
        input logic [7:0] vl,
        input logic [9:0] sew,
        input logic [3:0] vap,
        input int         n,
        input int         nwr,
        input logic       err,
        input int         lat
    );
        int  cnt;
        int  st0, rd0, wr0;
        bit  seen;
        push_writes(s1, s2, d, nwr);
        st0 = n_start;
        rd0 = n_ren;
        wr0 = n_wr;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(cmd_ready), 1);
        cmd_instr = ins;
        cmd_vs1   = s1;
        cmd_vs2   = s2;
        cmd_vd    = d;
        cmd_vl    = vl;
        cmd_sew   = sew;
        cmd_vap   = vap;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cnt  = 1;
        seen = 0;
        while (!seen && cnt < lat + 20) begin
            @(negedge clk);
            if (cnt == 2 && n > 0) begin
                chk({tag, "_busy"}, 64'(seq_busy), 1);
                chk({tag, "_pe_cmd"}, {42'd0, pe_instruction, pe_SEW, pe_vap},
                    {42'd0, ins, sew, vap});
            end
            if (seq_done) begin
                seen = 1;
            end else begin
                @(posedge clk);
                cnt++;
            end
        end
        chk({tag, "_latency"}, 64'(cnt), 64'(lat));
        chk({tag, "_err"}, 64'(seq_err), 64'(err));
        @(negedge clk);
        chk({tag, "_idle"}, {62'd0, cmd_ready, seq_done}, 64'b10);
        chk({tag, "_starts"}, 64'(n_start - st0), 64'(n));
        chk({tag, "_reads"}, 64'(n_ren - rd0), 64'(n));
        chk({tag, "_writes"}, 64'(n_wr - wr0), 64'(nwr));
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"},
            {57'd0, cmd_ready, rf_ren, rf_wen, pe_start,
             seq_busy, seq_done, seq_err}, 64'b1000000);
        chk({tag, "_addr"},
            {36'd0, rf_raddr1, rf_raddr2, rf_raddr3, rf_waddr}, 0);
        chk({tag, "_wdata_opA"}, {rf_wdata, pe_opA}, 0);
        chk({tag, "_opB_opC"}, {pe_opB, pe_opC}, 0);
        chk({tag, "_pe_cmd"}, {42'd0, pe_instruction, pe_SEW, pe_vap}, 0);
    endtask

    initial begin
        int cnt;
        int st0;
        for (int r = 0; r < 32; r++)
            for (int w = 0; w < 4; w++)
                vrf[r][w] = 32'h5a5a_0000 + 32'(r) * 32'h0101_0101
                          + 32'(w) * 32'h0010_0007;

        #3;
        chk_reset_vals("reset0");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        run_cmd("vadd32", 8'h00, 5'd1, 5'd2, 5'd3, 8'd4, 10'd32, 4'h5,
                4, 4, 1'b0, 21);
        run_cmd("vmul8", 8'h01, 5'd4, 5'd5, 5'd6, 8'd5, 10'd8, 4'h3,
                2, 2, 1'b0, 11);
        run_cmd("vdot16_clamp", 8'h02, 5'd7, 5'd8, 5'd9, 8'd200, 10'd16,
                4'ha, 4, 4, 1'b0, 21);
        run_cmd("vl0", 8'h00, 5'd1, 5'd2, 5'd3, 8'd0, 10'd32, 4'h0,
                0, 0, 1'b0, 1);
        run_cmd("sew64", 8'h03, 5'd1, 5'd2, 5'd3, 8'd4, 10'd64, 4'h1,
                0, 0, 1'b1, 1);

        pe_en   = 1'b0;
        pe_done = 1'b0;
        run_cmd("timeout", 8'h04, 5'd10, 5'd11, 5'd12, 8'd1, 10'd32,
                4'h2, 1, 0, 1'b1, 259);
        pe_en = 1'b1;

        // Reset during the WAIT cycle of word 2
        push_writes(5'd13, 5'd14, 5'd15, 4);
        st0 = n_start;
        @(negedge clk);
        cmd_instr = 8'h05;
        cmd_vs1   = 5'd13;
        cmd_vs2   = 5'd14;
        cmd_vd    = 5'd15;
        cmd_vl    = 8'd4;
        cmd_sew   = 10'd32;
        cmd_vap   = 4'h7;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cnt = 1;
        while (cnt < 14) begin
            @(posedge clk);
            cnt++;
        end
        @(negedge clk);
        chk("rst_mid_busy", {62'd0, seq_busy, pe_start}, 64'b10);
        #2 resetn = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        chk("rst_mid_words_written", 64'(exp_q.size()), 2);
        chk("rst_mid_starts", 64'(n_start - st0), 3);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst_hold");
        resetn = 1'b1;

        run_cmd("after_rst", 8'h00, 5'd13, 5'd14, 5'd15, 8'd3, 10'd32,
                4'h6, 3, 3, 1'b0, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
